// File: rtl/iso7816_vector_player_if.sv
// Bus bundle for the ISO7816 vector player: RAM load port, replay control and status.
// The bench drives through the master modport; the player sits on the slave modport.
interface iso7816_vector_player_if #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4096,
    parameter int RUN_W    = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = RUN_W + 2 * CHANNELS;

    logic                WR_EN;
    logic [AW-1:0]       WR_ADDR;
    logic [VW-1:0]       WR_DATA;
    logic                START;
    logic                STOP;
    logic                LOOP;
    logic [AW-1:0]       LAST_ADDR;
    logic [CHANNELS-1:0] CH_OUT;
    logic                BUSY;
    logic                DONE;
    logic [AW-1:0]       ADDR;
    logic [15:0]         LOOPS;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, START, STOP, LOOP, LAST_ADDR,
        input  CH_OUT, BUSY, DONE, ADDR, LOOPS
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, START, STOP, LOOP, LAST_ADDR,
        output CH_OUT, BUSY, DONE, ADDR, LOOPS
    );
endinterface

// File: rtl/iso7816_vector_player.sv
// Replays run-length encoded line vectors from an internal RAM onto CHANNELS outputs,
// with per-channel change masks, optional looping and a saturating pass counter.
module iso7816_vector_player #(
    parameter int                  CHANNELS   = 2,
    parameter int                  DEPTH      = 4096,
    parameter int                  RUN_W      = 8,
    parameter logic [CHANNELS-1:0] INIT_VALUE = '1
) (
    input logic                   CLK,
    input logic                   RST_N,
    iso7816_vector_player_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = RUN_W + 2 * CHANNELS;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        PLAY
    } state_t;

    state_t state, state_next;

    logic [VW-1:0]       mem [DEPTH];
    logic [VW-1:0]       vec_p1;
    logic [RUN_W-1:0]    run_p1;
    logic [CHANNELS-1:0] chg_p1;
    logic [CHANNELS-1:0] val_p1;

    logic [AW-1:0]       fetch_addr;
    logic [AW-1:0]       next_fetch;
    logic [AW-1:0]       last_addr;
    logic [AW-1:0]       last_clamped;
    logic                loop_en;
    logic [RUN_W-1:0]    hold_cnt;
    logic                first_vec;

    logic [CHANNELS-1:0] ch_out;
    logic [AW-1:0]       addr;
    logic [15:0]         loops;
    logic                done;

    logic do_start, do_prefetch, do_apply, do_count, pass_end, do_done;

    assign run_p1 = vec_p1[VW-1 -: RUN_W];
    assign chg_p1 = vec_p1[2*CHANNELS-1:CHANNELS];
    assign val_p1 = vec_p1[CHANNELS-1:0];

    // LAST_ADDR is only clamp-checked when DEPTH is not a power of two
    assign last_clamped = (int'(bus.LAST_ADDR) > DEPTH - 1) ? AW'(DEPTH - 1) : bus.LAST_ADDR;
    assign next_fetch   = (fetch_addr == last_addr) ? '0 : fetch_addr + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // hold_cnt counts the remaining extra cycles of the applied vector; zero means
    // this edge either applies the prefetched word or closes the pass
    always_comb begin
        state_next  = state;
        do_start    = 1'b0;
        do_prefetch = 1'b0;
        do_apply    = 1'b0;
        do_count    = 1'b0;
        pass_end    = 1'b0;
        do_done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START && !bus.STOP) begin
                    state_next = PREFETCH;
                    do_start   = 1'b1;
                end
            end
            PREFETCH: begin
                if (bus.STOP) begin
                    state_next = IDLE;
                end else begin
                    state_next  = PLAY;
                    do_prefetch = 1'b1;
                end
            end
            PLAY: begin
                if (bus.STOP) begin
                    state_next = IDLE;
                end else if (hold_cnt != '0) begin
                    do_count = 1'b1;
                end else if (!first_vec && addr == last_addr) begin
                    pass_end = 1'b1;
                    if (loop_en) begin
                        do_apply = 1'b1;
                    end else begin
                        state_next = IDLE;
                        do_done    = 1'b1;
                    end
                end else begin
                    do_apply = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ch_out     <= INIT_VALUE;
            addr       <= '0;
            loops      <= '0;
            done       <= 1'b0;
            hold_cnt   <= '0;
            first_vec  <= 1'b0;
            fetch_addr <= '0;
            last_addr  <= '0;
            loop_en    <= 1'b0;
        end else begin
            done <= do_done;
            if (do_start) begin
                last_addr <= last_clamped;
                loop_en   <= bus.LOOP;
                loops     <= '0;
            end
            if (do_prefetch) begin
                fetch_addr <= '0;
                hold_cnt   <= '0;
                first_vec  <= 1'b1;
            end
            if (do_count) hold_cnt <= hold_cnt - 1'b1;
            if (pass_end && loops != 16'hFFFF) loops <= loops + 1'b1;
            if (do_apply) begin
                ch_out     <= (ch_out & ~chg_p1) | (val_p1 & chg_p1);
                addr       <= fetch_addr;
                hold_cnt   <= run_p1;
                fetch_addr <= next_fetch;
                first_vec  <= 1'b0;
            end
        end
    end

    // Stage p1: the next word is read on every apply edge so vectors chain without bubbles
    always_ff @(posedge CLK) begin
        if (do_prefetch)   vec_p1 <= mem[0];
        else if (do_apply) vec_p1 <= mem[next_fetch];
    end

    always_ff @(posedge CLK) begin
        if (bus.WR_EN && state == IDLE && int'(bus.WR_ADDR) < DEPTH)
            mem[bus.WR_ADDR] <= bus.WR_DATA;
    end

    assign bus.CH_OUT = ch_out;
    assign bus.BUSY   = (state != IDLE);
    assign bus.DONE   = done;
    assign bus.ADDR   = addr;
    assign bus.LOOPS  = loops;
endmodule
